// File: rtl/compute_sched_if.sv
// compute_sched_if: job command, engine control and completion signals of the scheduler
interface compute_sched_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr_a;
  logic [ADDR_WIDTH-1:0] cmd_addr_b;
  logic [ADDR_WIDTH-1:0] cmd_addr_out;
  logic [31:0]           cmd_len;
  logic                  eng_start;
  logic [ADDR_WIDTH-1:0] eng_addr_a;
  logic [ADDR_WIDTH-1:0] eng_addr_b;
  logic [ADDR_WIDTH-1:0] eng_addr_out;
  logic [31:0]           eng_len;
  logic                  eng_done;
  logic                  cpl_valid;
  logic                  cpl_ready;
  logic [1:0]            cpl_status;
  modport master (
    output cmd_valid, cmd_addr_a, cmd_addr_b, cmd_addr_out, cmd_len, eng_done, cpl_ready,
    input  cmd_ready, eng_start, eng_addr_a, eng_addr_b, eng_addr_out, eng_len, cpl_valid, cpl_status
  );
  modport slave (
    input  cmd_valid, cmd_addr_a, cmd_addr_b, cmd_addr_out, cmd_len, eng_done, cpl_ready,
    output cmd_ready, eng_start, eng_addr_a, eng_addr_b, eng_addr_out, eng_len, cpl_valid, cpl_status
  );
endinterface

// File: rtl/compute_sched.sv
// compute_sched: FIFO-buffered job scheduler driving a single vector-add engine with timeout
module compute_sched #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  compute_sched_if.slave         bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int JW = 3 * ADDR_WIDTH + 32;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [PW:0]   FULL = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, COMPLETE} state_t;
  state_t          state_q, state_d;
  logic [JW-1:0]   mem_q [DEPTH];
  logic [JW-1:0]   mem_d [DEPTH];
  logic [JW-1:0]   job_q, job_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [1:0]      status_q, status_d;
  logic            push, pop;

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      state_q  <= IDLE;
      job_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    tmo_d    = tmo_q;
    status_d = status_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    pop      = 1'b0;
    push     = bus.cmd_valid && (cnt_q != FULL);
    if (push) begin
      mem_d[wr_q] = {bus.cmd_addr_a, bus.cmd_addr_b, bus.cmd_addr_out, bus.cmd_len};
      wr_d        = wr_q + 1'b1;
    end
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop      = 1'b1;
        job_d    = mem_q[rd_q];
        rd_d     = rd_q + 1'b1;
        state_d  = (mem_q[rd_q][31:0] == '0) ? COMPLETE : ISSUE;
        status_d = (mem_q[rd_q][31:0] == '0) ? 2'b01 : 2'b00;
      end
      ISSUE: begin
        state_d = RUN;
        tmo_d   = '0;
      end
      // eng_done takes priority over an expiring timer in the same cycle
      RUN: if (bus.eng_done) begin
        state_d  = COMPLETE;
        status_d = 2'b00;
      end else if (tmo_q == TMAX) begin
        state_d  = COMPLETE;
        status_d = 2'b10;
      end else tmo_d = tmo_q + 1'b1;
      COMPLETE: state_d = bus.cpl_ready ? IDLE : COMPLETE;
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
  end

  always_comb begin
    bus.cmd_ready  = cnt_q != FULL;
    bus.eng_start  = state_q == ISSUE;
    bus.cpl_valid  = state_q == COMPLETE;
    bus.cpl_status = status_q;
    {bus.eng_addr_a, bus.eng_addr_b, bus.eng_addr_out, bus.eng_len} = job_q;
    busy           = state_q != IDLE;
    pending        = cnt_q;
  end
endmodule

// File: tb/tb_compute_sched.sv
// tb_compute_sched: directed scoreboard bench for compute_sched (default and short-timeout instances)
module tb_compute_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy1, busy2;
  logic [2:0] pend1, pend2;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] o;
    logic [31:0] l;
  } job_t;
  job_t exp_q[$];

  compute_sched_if #(.ADDR_WIDTH(13)) b1 ();
  compute_sched_if #(.ADDR_WIDTH(13)) b2 ();

  compute_sched u_dut (.clk(clk), .rst(rst), .bus(b1), .busy(busy1), .pending(pend1));
  compute_sched #(.TIMEOUT(8)) u_to (.clk(clk), .rst(rst), .bus(b2), .busy(busy2), .pending(pend2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic offer(input logic [12:0] a, input logic [12:0] b, input logic [12:0] o,
                       input logic [31:0] l, input logic [1:0] st);
    b1.cmd_valid = 1'b1;
    b1.cmd_addr_a = a;
    b1.cmd_addr_b = b;
    b1.cmd_addr_out = o;
    b1.cmd_len = l;
    exp_q.push_back('{st, a, b, o, l});
    @(negedge clk);
  endtask

  task automatic expect_start(input int max);
    logic seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      seen = b1.eng_start;
    end
    chk("start_seen", seen, 1);
    if (seen && exp_q.size() > 0) begin
      chk("eng_addr_a", b1.eng_addr_a, exp_q[0].a);
      chk("eng_addr_b", b1.eng_addr_b, exp_q[0].b);
      chk("eng_addr_out", b1.eng_addr_out, exp_q[0].o);
      chk("eng_len", b1.eng_len, exp_q[0].l);
    end
  endtask

  task automatic finish_job();
    b1.eng_done = 1'b1;
    @(negedge clk);
    b1.eng_done = 1'b0;
    chk("cpl_valid", b1.cpl_valid, 1);
    if (exp_q.size() > 0) begin
      chk("cpl_status", b1.cpl_status, exp_q[0].st);
      void'(exp_q.pop_front());
    end else chk("sb_nonempty", 0, 1);
    @(negedge clk);
    chk("cpl_drop", b1.cpl_valid, 0);
  endtask

  initial begin
    {b1.cmd_valid, b1.eng_done, b2.cmd_valid, b2.eng_done} = '0;
    {b1.cmd_addr_a, b1.cmd_addr_b, b1.cmd_addr_out, b1.cmd_len} = '0;
    {b2.cmd_addr_a, b2.cmd_addr_b, b2.cmd_addr_out, b2.cmd_len} = '0;
    b1.cpl_ready = 1'b1;
    b2.cpl_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pending", pend1, 0);
    chk("rst_cmd_ready", b1.cmd_ready, 1);
    chk("rst_eng_start", b1.eng_start, 0);
    chk("rst_cpl_valid", b1.cpl_valid, 0);
    chk("rst_cpl_status", b1.cpl_status, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_eng_fields", {b1.eng_addr_a, b1.eng_addr_b, b1.eng_addr_out, b1.eng_len}, 0);
    rst = 1'b0;

    // single job: start at t+2, done at t+40, completion at t+41
    offer(13'd0, 13'd16, 13'd32, 32'd16, 2'b00);
    b1.cmd_valid = 1'b0;
    chk("lat_t1_start", b1.eng_start, 0);
    chk("lat_t1_pending", pend1, 1);
    expect_start(1);
    chk("lat_busy", busy1, 1);
    @(negedge clk);
    chk("lat_t3_start", b1.eng_start, 0);
    repeat (37) @(negedge clk);
    chk("lat_t40_cpl", b1.cpl_valid, 0);
    finish_job();
    chk("eng_hold_len", b1.eng_len, 16);
    chk("idle_busy", busy1, 0);

    // zero-length job is skipped; stray eng_done while idle is ignored
    offer(13'd1, 13'd2, 13'd3, 32'd0, 2'b01);
    b1.cmd_valid = 1'b0;
    chk("zl_t1_start", b1.eng_start, 0);
    finish_job();
    chk("zl_no_start", b1.eng_start, 0);

    // fill FIFO while completion is back-pressured, then drain in order
    b1.cpl_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(13'(100 + i), 13'(200 + i), 13'(300 + i), 32'(i + 1), 2'b00);
      if (i == 1) begin
        chk("q_j0_start", b1.eng_start, 1);
        chk("q_j0_addr", b1.eng_addr_a, 100);
      end
    end
    b1.cmd_addr_a = 13'd105;
    b1.cmd_addr_b = 13'd205;
    b1.cmd_addr_out = 13'd305;
    b1.cmd_len = 32'd6;
    chk("q_full_pending", pend1, 4);
    chk("q_full_ready", b1.cmd_ready, 0);
    b1.eng_done = 1'b1;
    @(negedge clk);
    b1.eng_done = 1'b0;
    chk("q_j0_cpl", b1.cpl_valid, 1);
    chk("q_j0_status", b1.cpl_status, exp_q[0].st);
    @(negedge clk);
    chk("q_cpl_hold", b1.cpl_valid, 1);
    chk("q_status_hold", b1.cpl_status, 0);
    chk("q_hold_ready", b1.cmd_ready, 0);
    void'(exp_q.pop_front());
    b1.cpl_ready = 1'b1;
    @(negedge clk);
    chk("q_pop_full_ready", b1.cmd_ready, 0);
    chk("q_pop_pending", pend1, 4);
    chk("q_pop_cpl", b1.cpl_valid, 0);
    @(negedge clk);
    chk("q_ready_again", b1.cmd_ready, 1);
    chk("q_j1_start", b1.eng_start, 1);
    chk("q_j1_addr", b1.eng_addr_a, exp_q[0].a);
    chk("q_j1_len", b1.eng_len, exp_q[0].l);
    exp_q.push_back('{2'b00, 13'd105, 13'd205, 13'd305, 32'd6});
    @(negedge clk);
    b1.cmd_valid = 1'b0;
    chk("q_refill_pending", pend1, 4);
    finish_job();
    for (int k = 0; k < 4; k++) begin
      expect_start(1);
      @(negedge clk);
      finish_job();
    end
    chk("q_drained_pending", pend1, 0);
    chk("q_drained_busy", busy1, 0);
    chk("q_sb_empty", exp_q.size(), 0);

    // reset mid-run with three jobs queued
    for (int i = 0; i < 4; i++) offer(13'(400 + i), 13'd1, 13'd2, 32'd9, 2'b00);
    b1.cmd_valid = 1'b0;
    chk("r_pre_busy", busy1, 1);
    chk("r_pre_pending", pend1, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("r_pending", pend1, 0);
    chk("r_busy", busy1, 0);
    chk("r_cpl_valid", b1.cpl_valid, 0);
    chk("r_cmd_ready", b1.cmd_ready, 1);
    chk("r_eng_len", b1.eng_len, 0);
    chk("r_eng_addr_a", b1.eng_addr_a, 0);
    b1.eng_done = 1'b1;
    @(negedge clk);
    b1.eng_done = 1'b0;
    chk("r_late_done_busy", busy1, 0);
    chk("r_late_done_cpl", b1.cpl_valid, 0);

    // TIMEOUT=8 instance: timeout, then next job with done on the timeout cycle
    b2.cmd_valid = 1'b1;
    b2.cmd_addr_a = 13'd7;
    b2.cmd_len = 32'd4;
    @(negedge clk);
    b2.cmd_addr_a = 13'd9;
    @(negedge clk);
    b2.cmd_valid = 1'b0;
    chk("to_x_start", b2.eng_start, 1);
    chk("to_x_addr", b2.eng_addr_a, 7);
    repeat (8) @(negedge clk);
    chk("to_x_early", b2.cpl_valid, 0);
    @(negedge clk);
    chk("to_x_cpl", b2.cpl_valid, 1);
    chk("to_x_status", b2.cpl_status, 2'b10);
    @(negedge clk);
    chk("to_x_drop", b2.cpl_valid, 0);
    @(negedge clk);
    chk("to_y_start", b2.eng_start, 1);
    chk("to_y_addr", b2.eng_addr_a, 9);
    repeat (8) @(negedge clk);
    chk("to_y_early", b2.cpl_valid, 0);
    b2.eng_done = 1'b1;
    @(negedge clk);
    b2.eng_done = 1'b0;
    chk("to_y_cpl", b2.cpl_valid, 1);
    chk("to_y_status", b2.cpl_status, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/compute_sched.md
COMPUTE_SCHED -- requirements
Module: compute_sched

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, BRAM word-address width of job addresses.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max RUN cycles before a job is abandoned.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have ports cmd_valid input 1 / cmd_ready output 1: job offer and FIFO-accept handshake.
REQ-007 SHALL have ports cmd_addr_a, cmd_addr_b, cmd_addr_out  input  ADDR_WIDTH each: source A, source B and destination base addresses.
REQ-008 SHALL have port cmd_len  input  32  element count.
REQ-009 SHALL have port eng_start  output  1  single-cycle start pulse to the vector-add engine.
REQ-010 SHALL have ports eng_addr_a, eng_addr_b, eng_addr_out  output  ADDR_WIDTH each, and eng_len  output  32: job fields of the current job.
REQ-011 SHALL have port eng_done  input  1  engine completion pulse.
REQ-012 SHALL have ports cpl_valid output 1 / cpl_ready input 1 / cpl_status output 2: completion report (00 ok, 01 zero-length skipped, 10 timeout).
REQ-013 SHALL have ports busy  output  1 (state != IDLE) and pending  output  $clog2(DEPTH)+1 (FIFO occupancy).

Function
REQ-014 A job SHALL be pushed when cmd_valid && cmd_ready; cmd_ready SHALL equal (pending < DEPTH), with no combinational dependence on cmd_valid.
REQ-015 FSM states SHALL be IDLE, ISSUE, RUN, COMPLETE.
REQ-016 IDLE: if pending > 0, the head SHALL be popped into job registers; go to COMPLETE with status 01 if its len == 0, else to ISSUE.
REQ-017 ISSUE: eng_start SHALL be 1 for exactly this one cycle; next state RUN; timeout counter cleared.
REQ-018 RUN: eng_done SHALL move to COMPLETE with status 00; otherwise the counter increments, and when it reaches TIMEOUT-1 without eng_done the FSM SHALL move to COMPLETE with status 10.
REQ-019 If eng_done and timeout coincide in the same cycle, status SHALL be 00.
REQ-020 eng_done SHALL be ignored outside RUN.
REQ-021 COMPLETE: cpl_valid SHALL be 1 and cpl_status stable until cpl_ready; on handshake, return to IDLE.
REQ-022 eng_addr_* and eng_len SHALL hold the popped job's values from ISSUE until the next pop.
REQ-023 Push and pop in the same cycle SHALL leave pending unchanged, with both operations taking effect.
REQ-024 When pending = DEPTH, cmd_ready SHALL be 0 in that cycle, even if a pop occurs in the same cycle.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH; job order SHALL be strictly FIFO.
REQ-026 Latency: job pushed at cycle t into an empty FIFO while IDLE -> eng_start SHALL be high at cycle t+2.
REQ-027 Back-to-back: the next job SHALL be popped in the cycle after the cpl handshake.

Reset
REQ-028 With rst high at a clock edge: state=IDLE; FIFO emptied (pending=0); cmd_ready=1; eng_start=0; cpl_valid=0; cpl_status=00; busy=0; eng_addr_*=0; eng_len=0; timeout counter=0.
REQ-029 Reset mid-job (any state) SHALL discard the current job and all queued jobs, and SHALL issue no completion.

Verification
REQ-030 Push {a=0,b=16,out=32,len=16} at t; eng_done at t+40 -> eng_start only at t+2, eng_* = 0/16/32/16, cpl_status=00, cpl_valid at t+41.
REQ-031 Push len=0 -> no eng_start; cpl_valid with status 01 two cycles after push.
REQ-032 With TIMEOUT=8 and eng_done never asserted -> cpl_status=10 after 8 RUN cycles; next job then issues.
REQ-033 Hold cpl_ready=0 while pushing 5 jobs (DEPTH=4) -> first job is popped, then 4 more accepted, pending=4, cmd_ready=0; release cpl_ready -> jobs run in push order, and addresses wrap correctly.
REQ-034 Assert rst during RUN with 3 jobs queued -> next cycle pending=0, busy=0, cpl_valid=0; a late eng_done is ignored.
REQ-035 eng_done coinciding with the timeout cycle -> status 00.
